// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab datapath: FSM state encoding and
// a counter-width helper used by the multiplier and divider.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold values 0..value-1; elaborates to a constant.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        bits = bits + 1;
        rem  = rem >> 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-and-add iteration on the {A, Qr} register pair.
module mul_step #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH:0]   a_in,
  input  logic [WIDTH-1:0] qr_in,
  input  logic [WIDTH-1:0] mr_in,
  output logic [WIDTH:0]   a_out,
  output logic [WIDTH-1:0] qr_out
);

  logic [WIDTH:0] sum;

  // A stays below 2^WIDTH between steps, so the WIDTH+1 bit sum never overflows.
  always_comb begin
    sum    = a_in + (qr_in[0] ? {1'b0, mr_in} : '0);
    a_out  = {1'b0, sum[WIDTH:1]};
    qr_out = {sum[0], qr_in[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_mul_add.sv
// Sequential unsigned multiply-add: product = multiplicand * multiplier + addend,
// one shift-and-add step per cycle, start/busy/done handshake.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one shift-and-add step per cycle, count down from WIDTH
// DONE    | done pulse, product valid; start here chains the next operation
module seq_mul_add
  import arith_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   qr_q, qr_d;
  logic [WIDTH-1:0]   mr_q, mr_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     a_nxt;
  logic [WIDTH-1:0]   qr_nxt;
  logic               load;
  logic               last_step;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .a_in   (a_q),
    .qr_in  (qr_q),
    .mr_in  (mr_q),
    .a_out  (a_nxt),
    .qr_out (qr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      qr_q      <= '0;
      mr_q      <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      qr_q      <= qr_d;
      mr_q      <= mr_d;
      product_q <= product_d;
    end
  end

  assign load      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_step = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The addend sits in the high half at load and shifts down WIDTH places
  // into the low half, so no separate final add is needed.
  always_comb begin
    cnt_d     = cnt_q;
    a_d       = a_q;
    qr_d      = qr_q;
    mr_d      = mr_q;
    product_d = product_q;
    if (load) begin
      a_d   = {1'b0, addend};
      qr_d  = multiplier;
      mr_d  = multiplicand;
      cnt_d = CNT_W'(WIDTH);
    end else if (state_q == ST_RUN) begin
      a_d   = a_nxt;
      qr_d  = qr_nxt;
      cnt_d = cnt_q - CNT_W'(1);
      if (last_step) product_d = {a_nxt[WIDTH-1:0], qr_nxt};
    end
  end

  always_comb begin
    busy    = (state_q == ST_RUN);
    done    = (state_q == ST_DONE);
    product = product_q;
  end

endmodule

// File: tb/tb_seq_mul_add.sv
// Directed self-checking bench for seq_mul_add at WIDTH=2 and WIDTH=8.
module tb_seq_mul_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        start2, start8;
  logic [1:0]  m2, q2, c2;
  logic [7:0]  m8, q8, c8;
  logic        busy2, done2, busy8, done8;
  logic [3:0]  prod2;
  logic [15:0] prod8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mul_add #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .multiplicand(m2), .multiplier(q2), .addend(c2),
    .busy(busy2), .done(done2), .product(prod2)
  );

  seq_mul_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .multiplicand(m8), .multiplier(q8), .addend(c8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge; returns at the negedge after accept.
  task automatic accept2(input logic [1:0] m, input logic [1:0] q, input logic [1:0] c);
    @(negedge clk);
    m2 = m; q2 = q; c2 = c; start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic accept8(input logic [7:0] m, input logic [7:0] q, input logic [7:0] c);
    @(negedge clk);
    m8 = m; q8 = q; c8 = c; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // lat = edges after the accept edge until done is seen; bounded.
  task automatic wait_done2(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (!done2 && lat < 40) begin
      if (busy2) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done8(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, cyc, n, seen;
    logic stable;
    logic [15:0] p_hold;
    int exp_b2b[3];
    exp_b2b = '{35, 4, 601};

    rst = 1'b1; start2 = 1'b0; start8 = 1'b0;
    m2 = '0; q2 = '0; c2 = '0; m8 = '0; q8 = '0; c8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy2", busy2, 0);
    check("rst_done2", done2, 0);
    check("rst_prod2", prod2, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_prod8", prod8, 0);

    // Divider cross-check 3/2 -> q=1 r=1
    accept2(2'd2, 2'd1, 2'd1);
    wait_done2(lat, bc);
    check("w2_lat", lat, 2);
    check("w2_busy_cycles", bc, 2);
    check("w2_prod", prod2, 3);
    @(negedge clk);
    check("w2_done_pulse", done2, 0);

    for (int m = 0; m < 4; m++)
      for (int q = 0; q < 4; q++)
        for (int c = 0; c < 4; c++) begin
          accept2(2'(m), 2'(q), 2'(c));
          wait_done2(lat, bc);
          check("exh_lat", lat, 2);
          check("exh_prod", prod2, m * q + c);
        end

    accept8(8'hFF, 8'hFF, 8'hFF);
    wait_done8(lat, bc);
    check("max_lat", lat, 8);
    check("max_busy_cycles", bc, 8);
    check("max_prod", prod8, 16'hFF00);

    // start held high across three operations
    @(negedge clk);
    m8 = 8'd5; q8 = 8'd7; c8 = 8'd0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        m8 = 8'd0; q8 = 8'd9; c8 = 8'd4;
      end else if (i == 1) begin
        m8 = 8'd200; q8 = 8'd3; c8 = 8'd1;
      end else begin
        start8 = 1'b0;
      end
      p_hold = prod8; stable = 1'b1; n = 0;
      while (!done8 && n < 40) begin
        if (prod8 !== p_hold) stable = 1'b0;
        @(negedge clk);
        n++; cyc++;
      end
      check("b2b_prod", prod8, exp_b2b[i]);
      check("b2b_stable", stable, 1);
      check("b2b_done_cycle", cyc, 8 + 9 * i);
      if (i < 2) begin
        @(negedge clk);
        cyc++;
      end
    end

    // start pulsed mid-RUN with different operands must be ignored
    accept8(8'd10, 8'd10, 8'd0);
    repeat (3) @(negedge clk);
    m8 = 8'd3; q8 = 8'd3; c8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(lat, bc);
    check("midrun_lat", lat, 4);
    check("midrun_prod", prod8, 100);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("midrun_no_extra_done", seen, 0);
    check("midrun_prod_hold", prod8, 100);

    // Reset while count == 4
    accept8(8'd10, 8'd10, 8'd5);
    repeat (4) @(negedge clk);
    check("abort_busy_before", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_prod", prod8, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("abort_no_done", seen, 0);
    accept8(8'd3, 8'd4, 8'd5);
    wait_done8(lat, bc);
    check("post_abort_lat", lat, 8);
    check("post_abort_prod", prod8, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
